seq_divider_core: RTL and testbench

//   Iterative radix-2 restoring divider: one quotient bit per clock.

---
 rtl/seq_divider_pkg.sv | 24 ++
 rtl/seq_divider_step.sv | 38 +++
 rtl/seq_divider_core.sv | 162 ++++++++++++++++
 tb/tb_seq_divider_core.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared types and constants for the sequential restoring divider.
//   - state_t       : FSM states of seq_divider_core
//   - DEFAULT_WIDTH : default operand/result width
//   - cnt_width()   : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// -----------------------------------------------------------------------------
// seq_divider_step
//   Combinational single step of a radix-2 restoring division:
//   shift the next dividend bit into the partial remainder, compare against
//   the divisor, subtract when it fits and record the quotient bit.
// Ports
//   rem     in  WIDTH  current partial remainder (always < den after a step)
//   quo     in  WIDTH  dividend bits still to consume / quotient bits so far
//   den     in  WIDTH  divisor
//   rem_nxt out WIDTH  partial remainder after this step
//   quo_nxt out WIDTH  shifted quotient with the new bit in the LSB
// -----------------------------------------------------------------------------
module seq_divider_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  // One extra bit so the shifted remainder never overflows the compare.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    diff    = trial - {1'b0, den};
    fits    = (trial >= {1'b0, den});
    rem_nxt = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider_core.sv
// -----------------------------------------------------------------------------
// seq_divider_core
//   Iterative radix-2 restoring divider producing one quotient bit per clock.
//   A start pulse in IDLE/DONE latches n/d; done rises WIDTH edges later
//   (WIDTH+1 in the signed build) and q/r then hold until the next start.
//   Divide by zero follows the plain algorithm: q = all-ones, r = n.
// Configuration
//   SEQ_DIVIDER_SIGNED_EN : two's complement operands; magnitudes are divided
//                           and an extra FIX cycle applies the signs
//                           (truncating quotient, remainder takes sign of n).
// Ports
//   mclk     in   1      system clock
//   puc_rst  in   1      asynchronous active-high reset
//   start    in   1      one-cycle request, n/d sampled on the same edge
//   n        in   WIDTH  dividend
//   d        in   WIDTH  divisor
//   q        out  WIDTH  quotient (registered)
//   r        out  WIDTH  remainder (registered)
//   busy     out  1      division in progress
//   done     out  1      result valid, until the next accepted start
// -----------------------------------------------------------------------------
module seq_divider_core
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] den_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;
  logic             accept;
  logic             last_bit;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             r_neg_q;
  logic             q_neg_q;
`endif

  seq_divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .den     (den_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_comb begin
    accept   = start && ((state == IDLE) || (state == DONE));
    last_bit = (state == CALC) && (cnt_q == CNT_ONE);
`ifdef SEQ_DIVIDER_SIGNED_EN
    n_mag    = n[WIDTH-1] ? -n : n;
    d_mag    = d[WIDTH-1] ? -d : d;
`else
    n_mag    = n;
    d_mag    = d;
`endif
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (last_bit) state_nxt = FIX;
`else
        if (last_bit) state_nxt = DONE;
`endif
      end
      FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        busy      = 1'b1;
        state_nxt = DONE;
`else
        state_nxt = IDLE;
`endif
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      q       <= '0;
      r       <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
`endif
    end else if (accept) begin
      rem_q   <= '0;
      quo_q   <= n_mag;
      den_q   <= d_mag;
      cnt_q   <= CNT_INIT;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q <= n[WIDTH-1];
      // Divisor magnitude of zero keeps the quotient unsigned-all-ones,
      // negated only by the dividend sign.
      q_neg_q <= n[WIDTH-1] ^ d[WIDTH-1];
`endif
    end else if (state == CALC) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CNT_ONE;
`ifndef SEQ_DIVIDER_SIGNED_EN
      if (last_bit) begin
        q <= quo_nxt;
        r <= rem_nxt;
      end
`endif
    end
`ifdef SEQ_DIVIDER_SIGNED_EN
    else if (state == FIX) begin
      q <= q_neg_q ? -quo_q : quo_q;
      r <= r_neg_q ? -rem_q : rem_q;
    end
`endif
  end

endmodule

// File: tb/tb_seq_divider_core.sv
module tb_seq_divider_core;

  localparam int W = 16;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic         mclk    = 1'b0;
  logic         puc_rst = 1'b1;
  logic         start   = 1'b0;
  logic [W-1:0] n       = '0;
  logic [W-1:0] d       = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  always #5 mclk = ~mclk;

  seq_divider_core #(
    .WIDTH (W)
  ) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .start   (start),
    .n       (n),
    .d       (d),
    .q       (q),
    .r       (r),
    .busy    (busy),
    .done    (done)
  );

  // Reference: plain arithmetic on the operands as numbers.
  function automatic void ref_div(input logic [W-1:0] nn, input logic [W-1:0] dd,
                                  output logic [W-1:0] qe, output logic [W-1:0] re);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sn;
    int sd;
    sn = int'($signed(nn));
    sd = int'($signed(dd));
    if (sd == 0) begin
      qe = (sn < 0) ? W'(1) : '1;
      re = nn;
    end else begin
      qe = W'(sn / sd);
      re = W'(sn % sd);
    end
`else
    if (dd == '0) begin
      qe = '1;
      re = nn;
    end else begin
      qe = nn / dd;
      re = nn % dd;
    end
`endif
  endfunction

  // Issue one division and wait (bounded) for done. Inputs are scrambled
  // right after the start edge; q/r are watched for stability meanwhile.
  task automatic run_div(input logic [W-1:0] nn, input logic [W-1:0] dd,
                         output logic [W-1:0] qo, output logic [W-1:0] ro,
                         output int lat, output bit busy_ok, output bit hold_ok,
                         output bit done0, output bit busy0);
    logic [W-1:0] qprev;
    logic [W-1:0] rprev;
    @(negedge mclk);
    qprev = q;
    rprev = r;
    n     = nn;
    d     = dd;
    start = 1'b1;
    @(posedge mclk);
    #1;
    start   = 1'b0;
    done0   = done;
    busy0   = busy;
    n       = W'($urandom);
    d       = W'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && lat < LAT + 8) begin
      if (!busy) busy_ok = 1'b0;
      if (q !== qprev || r !== rprev) hold_ok = 1'b0;
      @(posedge mclk);
      #1;
      lat++;
    end
    qo = q;
    ro = r;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({q, r, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_hold: q=%h r=%h busy=%b done=%b required all zero", q, r, busy, done);
    end
    @(negedge mclk);
    puc_rst = 1'b0;
    @(posedge mclk);
    #1;
    checks++;
    if ({q, r, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_release: q=%h r=%h busy=%b done=%b required all zero", q, r, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] qo, ro;
    int lat;
    bit bok, hok, d0, b0;
    run_div(16'd100, 16'd7, qo, ro, lat, bok, hok, d0, b0);
    checks++;
    if (qo !== 16'd14 || ro !== 16'd2) begin
      errors++;
      $display("FAIL basic_100_7: q=%0d r=%0d required q=14 r=2", qo, ro);
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges required %0d", lat, LAT);
    end
    checks++;
    if (!bok || !b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: during=%b at_start=%b after=%b required 1 1 0", bok, b0, busy);
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] qo, ro;
    int lat;
    bit bok, hok, d0, b0;
    run_div(16'h04D2, 16'h0000, qo, ro, lat, bok, hok, d0, b0);
    checks++;
    if (qo !== 16'hFFFF || ro !== 16'h04D2 || lat !== LAT) begin
      errors++;
      $display("FAIL div_zero: q=%h r=%h lat=%0d required q=ffff r=04d2 lat=%0d", qo, ro, lat, LAT);
    end
  endtask

  task automatic test_sign_mode();
    logic [W-1:0] qo, ro;
    int lat;
    bit bok, hok, d0, b0;
    run_div(16'hFFF9, 16'h0002, qo, ro, lat, bok, hok, d0, b0);
    checks++;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (qo !== 16'hFFFD || ro !== 16'hFFFF || lat !== 17) begin
      errors++;
      $display("FAIL signed_neg7_2: q=%h r=%h lat=%0d required q=fffd r=ffff lat=17", qo, ro, lat);
    end
    run_div(16'h8000, 16'hFFFF, qo, ro, lat, bok, hok, d0, b0);
    checks++;
    if (qo !== 16'h8000 || ro !== 16'h0000) begin
      errors++;
      $display("FAIL signed_min_m1: q=%h r=%h required q=8000 r=0000", qo, ro);
    end
`else
    if (qo !== 16'h7FFC || ro !== 16'h0001 || lat !== 16) begin
      errors++;
      $display("FAIL unsigned_fff9_2: q=%h r=%h lat=%0d required q=7ffc r=0001 lat=16", qo, ro, lat);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] qo, ro;
    int lat;
    bit bok, hok, d0, b0;
    run_div(16'hFFFF, 16'h0001, qo, ro, lat, bok, hok, d0, b0);
    checks++;
    if (qo !== 16'hFFFF || ro !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_first: q=%h r=%h required q=ffff r=0000", qo, ro);
    end
    run_div(16'd5, 16'd9, qo, ro, lat, bok, hok, d0, b0);
    checks++;
    if (d0 !== 1'b0 || b0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start_edge: done=%b busy=%b required done=0 busy=1", d0, b0);
    end
    checks++;
    if (!hok) begin
      errors++;
      $display("FAIL b2b_hold: q/r changed during CALC, required held at ffff/0000");
    end
    checks++;
    if (qo !== 16'd0 || ro !== 16'd5 || lat !== LAT) begin
      errors++;
      $display("FAIL b2b_second: q=%h r=%h lat=%0d required q=0000 r=0005 lat=%0d", qo, ro, lat, LAT);
    end
  endtask

  task automatic test_restart_ignored();
    int lat;
    @(negedge mclk);
    n     = 16'd1000;
    d     = 16'd3;
    start = 1'b1;
    @(posedge mclk);
    #1;
    start = 1'b0;
    lat   = 0;
    repeat (4) begin
      @(posedge mclk);
      #1;
      lat++;
    end
    @(negedge mclk);
    n     = 16'd9;
    d     = 16'd2;
    start = 1'b1;
    @(posedge mclk);
    #1;
    start = 1'b0;
    lat++;
    while (!done && lat < LAT + 8) begin
      @(posedge mclk);
      #1;
      lat++;
    end
    checks++;
    if (q !== 16'd333 || r !== 16'd1 || lat !== LAT) begin
      errors++;
      $display("FAIL restart_ignored: q=%0d r=%0d lat=%0d required q=333 r=1 lat=%0d", q, r, lat, LAT);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [W-1:0] qo, ro, qe, re;
    int lat;
    bit bok, hok, d0, b0;
    @(negedge mclk);
    n     = 16'h1234;
    d     = 16'h0077;
    start = 1'b1;
    @(posedge mclk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge mclk);
    @(negedge mclk);
    puc_rst = 1'b1;
    #1;
    checks++;
    if ({q, r, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_calc: q=%h r=%h busy=%b done=%b required all zero", q, r, busy, done);
    end
    @(negedge mclk);
    puc_rst = 1'b0;
    run_div(16'hBEEF, 16'h0013, qo, ro, lat, bok, hok, d0, b0);
    ref_div(16'hBEEF, 16'h0013, qe, re);
    checks++;
    if (qo !== qe || ro !== re || lat !== LAT) begin
      errors++;
      $display("FAIL after_reset: q=%h r=%h lat=%0d required q=%h r=%h lat=%0d", qo, ro, lat, qe, re, LAT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] nn, dd, qo, ro, qe, re;
    int lat;
    bit bok, hok, d0, b0;
    for (int i = 0; i < 60; i++) begin
      nn = W'($urandom);
      case ($urandom_range(0, 7))
        0:       dd = '0;
        1:       dd = W'(1);
        2:       dd = W'($urandom_range(2, 15));
        3:       begin nn = 16'h8000; dd = 16'hFFFF; end
        4:       dd = 16'hFFFF;
        default: dd = W'($urandom);
      endcase
      run_div(nn, dd, qo, ro, lat, bok, hok, d0, b0);
      ref_div(nn, dd, qe, re);
      checks++;
      if (qo !== qe || ro !== re || lat !== LAT || !bok) begin
        errors++;
        $display("FAIL random_%0d: %h/%h q=%h r=%h lat=%0d busy_ok=%b required q=%h r=%h lat=%0d",
                 i, nn, dd, qo, ro, lat, bok, qe, re, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_sign_mode();
    test_back_to_back();
    test_restart_ignored();
    test_reset_mid_calc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
